booth_mul_seq: RTL
==================

BOOTH_MUL_SEQ -- requirements
Module: booth_mul_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand width; legal values are even and >= 4.
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port clear, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: request to begin a multiply.
REQ-005 SHALL have port is_signed, input, 1 bit: 1 selects two's-complement operands, 0 selects unsigned operands.
REQ-006 SHALL have port a, input, WIDTH bits: multiplicand.
REQ-007 SHALL have port b, input, WIDTH bits: multiplier.
REQ-008 SHALL have port busy, output, 1 bit: high while a multiply is in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse marking a valid result.
REQ-010 SHALL have port Zlowout, output, WIDTH bits: product bits [WIDTH-1:0].
REQ-011 SHALL have port Zhighout, output, WIDTH bits: product bits [2*WIDTH-1:WIDTH].

Function
REQ-012 SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-013 SHALL move from IDLE or DONE to RUN on a rising edge where start=1, latching a, b and is_signed on that edge.
REQ-014 SHALL ignore later changes to a, b, is_signed and start while in RUN.
REQ-015 SHALL extend both latched operands to WIDTH+2 bits: sign-extended when is_signed=1, zero-extended when is_signed=0.
REQ-016 SHALL use radix-4 Booth recoding of the extended multiplier, one digit per RUN cycle, LSB digit first; the implicit bit below bit 0 is 0.
REQ-017 SHALL process N = WIDTH/2+1 digits per multiply.
REQ-018 SHALL map each digit {b[2j+1], b[2j], b[2j-1]} to a multiplicand multiple: 000/111 -> 0; 001/010 -> +A; 011 -> +2A; 100 -> -2A; 101/110 -> -A.
REQ-019 SHALL perform all multiples and accumulation at a width of at least 2*WIDTH+4 bits, two's-complement, with an arithmetic right shift of 2 bits per digit.
REQ-020 SHALL move from RUN to DONE after exactly N RUN cycles.
REQ-021 SHALL assert done for exactly one cycle, beginning N+1 rising edges after the edge that sampled start.
REQ-022 SHALL hold busy=1 for the N RUN cycles only, and busy=0 in IDLE and DONE.
REQ-023 SHALL, in the DONE cycle, make Zhighout:Zlowout equal the exact 2*WIDTH-bit product, signed or unsigned per the latched is_signed.
REQ-024 SHALL hold Zlowout and Zhighout at the last result until the next DONE.
REQ-025 SHALL keep outputs unchanged during RUN.
REQ-026 SHALL transition DONE -> IDLE when start=0, and DONE -> RUN when start=1 (back-to-back operation, no idle cycle required).
REQ-027 SHALL have no overflow case: the full product always fits, including (-2^(W-1))^2 and (2^W-1)^2.

Reset
REQ-028 SHALL, while clear=1, independent of clock, force state=IDLE, busy=0, done=0, Zlowout=0 and Zhighout=0, and zero all internal operand and accumulator registers.
REQ-029 SHALL, when clear asserts mid-RUN, abort the operation with no done pulse; after clear is released, the block accepts a new start normally.

Verification
REQ-030 SHALL verify: WIDTH=32, is_signed=1, a=0xFFFFFFF9 (-7), b=3 -> done pulse, Zhighout=0xFFFFFFFF, Zlowout=0xFFFFFFEB.
REQ-031 SHALL verify: WIDTH=32, is_signed=0, a=b=0xFFFFFFFF -> Zhighout=0xFFFFFFFE, Zlowout=0x00000001; the same operands with is_signed=1 -> Zhighout=0, Zlowout=1.
REQ-032 SHALL verify: WIDTH=32, is_signed=1, a=b=0x80000000 -> Zhighout=0x40000000, Zlowout=0; done exactly 18 edges after start; busy high for 17 cycles.
REQ-033 SHALL verify: start pulsed again during RUN, and a/b changed mid-RUN -> ignored, with the result matching the originally latched operands.
REQ-034 SHALL verify: clear asserted at RUN cycle 5 -> busy=0, outputs=0 immediately, no done pulse; the next multiply, 6x7, -> Zlowout=42, Zhighout=0.
REQ-035 SHALL verify: WIDTH=8, is_signed=1, a=b=0x80 -> Zhighout=0x40, Zlowout=0x00; with start held high, back-to-back results arrive every 6 cycles.

Source files
------------

// File: rtl/booth_mul_seq.sv
// -----------------------------------------------------------------------------
// booth_mul_seq
//   Sequential radix-4 Booth multiplier. It handles one Booth digit per clock,
//   so a multiply takes N = WIDTH/2+1 RUN cycles followed by one DONE cycle.
//   With start held high the block runs back-to-back, one result every N+1
//   cycles.
//
// Ports
//   clock     : single clock, rising edge
//   clear     : asynchronous active-high reset
//   start     : begin a multiply (sampled in IDLE or DONE)
//   is_signed : 1 = two's-complement operands, 0 = unsigned operands
//   a, b      : multiplicand and multiplier (WIDTH bits each)
//   busy      : high during the N RUN cycles
//   done      : one-cycle pulse; the product is valid in this cycle
//   Zlowout   : product bits [WIDTH-1:0], held until the next result
//   Zhighout  : product bits [2*WIDTH-1:WIDTH], held until the next result
// -----------------------------------------------------------------------------
module booth_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Zlowout,
    output logic [WIDTH-1:0] Zhighout
);

    // Digit count, extended operand width, accumulator width, and the
    // alignment shift for each multiple.
    localparam int N  = WIDTH / 2 + 1;
    localparam int EW = WIDTH + 2;
    localparam int AW = 2 * WIDTH + 4;
    localparam int SH = 2 * N;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    logic [EW-1:0] mcand;   // extended multiplicand
    logic [EW:0]   mplier;  // extended multiplier with the implicit 0 at bit 0
    logic [AW-1:0] acc;
    logic [CW-1:0] cnt;

    logic                 last;
    logic                 load;
    logic [2:0]           digit;
    logic [AW-1:0]        mcand_ext;
    logic [AW-1:0]        multiple;
    logic signed [AW-1:0] sum;
    logic [AW-1:0]        acc_nx;
    logic [EW-1:0]        a_ext;
    logic [EW-1:0]        b_ext;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    assign last = (cnt == CW'(N - 1));

    always_ff @(posedge clock or posedge clear) begin
        if (clear) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last)  state_nx = DONE;
            DONE:    state_nx = start ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    // A new operation is accepted from IDLE or DONE only. In RUN, start and
    // the operand inputs are ignored.
    assign load = start && (state != RUN);

    // ------------------------------------------------------------------
    // Operand extension to WIDTH+2 bits. This range holds both signed and
    // unsigned operands, so one signed Booth datapath serves both modes.
    // ------------------------------------------------------------------
    assign a_ext = is_signed ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
    assign b_ext = is_signed ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};

    // ------------------------------------------------------------------
    // Booth step
    // ------------------------------------------------------------------
    assign digit     = mplier[2:0];
    assign mcand_ext = {{(AW-EW){mcand[EW-1]}}, mcand};

    always_comb begin
        multiple = '0;
        case (digit)
            3'b001, 3'b010: multiple = mcand_ext;
            3'b011:         multiple = mcand_ext << 1;
            3'b100:         multiple = -(mcand_ext << 1);
            3'b101, 3'b110: multiple = -mcand_ext;
            default:        multiple = '0;
        endcase
    end

    // Each multiple enters at the top, 2N bits up, and then moves down by 2
    // bits per digit. After N digits, digit j has weight 4^j, and acc holds
    // the exact product with no fractional bits. The low bits that are
    // shifted out are always zero. The running partial sum stays below
    // 2^(2*WIDTH+3) in magnitude, so AW bits cannot overflow.
    assign sum    = $signed(acc) + $signed(multiple << SH);
    assign acc_nx = sum >>> 2;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            cnt      <= '0;
            Zlowout  <= '0;
            Zhighout <= '0;
        end else if (load) begin
            mcand  <= a_ext;
            mplier <= {b_ext, 1'b0};
            acc    <= '0;
            cnt    <= '0;
        end else if (state == RUN) begin
            acc    <= acc_nx;
            mplier <= {2'b00, mplier[EW:2]};
            cnt    <= cnt + 1'b1;
            // The outputs change only on entry to DONE, so they hold
            // steady through RUN.
            if (last) begin
                Zlowout  <= acc_nx[WIDTH-1:0];
                Zhighout <= acc_nx[2*WIDTH-1:WIDTH];
            end
        end
    end

endmodule
